// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx
//  Purpose  : Step-driven serial pattern generator. On start, captures a
//             pattern word D and frame length L+1, then presents one bit per
//             step pulse on X, MSB of the frame (D[L]) first. One-shot or
//             continuous repeat selected by M at each frame's final step.
//  Ports    : clk    - system clock, rising edge
//             reset  - synchronous active-high reset
//             step   - single-cycle advance pulse
//             start  - load-and-begin request (ignored while sending)
//             M      - 0 = one-shot, 1 = continuous repeat
//             D[15:0]- pattern word
//             L[3:0] - frame length minus one
//             X      - serial bit out
//             valid  - X carries a pattern bit
//             busy   - frame in progress
//             done   - one-cycle pulse after the completing step
//             cnt    - index of the bit currently on X
//  Revision : 1.0  initial release
// ============================================================================
module serial_pattern_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        start,
    input  logic        M,
    input  logic [15:0] D,
    input  logic [3:0]  L,
    output logic        X,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_sr;
    logic [15:0] w_sr_nxt;
    logic [15:0] r_pat;
    logic [15:0] w_pat_nxt;
    logic [3:0]  r_len;
    logic [3:0]  w_len_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_x;
    logic        w_valid;
    logic        w_busy;
    logic [3:0]  w_load_shamt;
    logic [3:0]  w_reload_shamt;

    // Left-align the frame so that its first bit (D[L]) sits at sr[15].
    assign w_load_shamt   = 4'd15 - L;
    assign w_reload_shamt = 4'd15 - r_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sr    <= 16'd0;
            r_pat   <= 16'd0;
            r_len   <= 4'd0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_x         = 1'b0;
        w_valid     = 1'b0;
        w_busy      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A step arriving with start is deliberately dropped so the
                // first bit is always presented with cnt = 0.
                if (start) begin
                    w_pat_nxt   = D;
                    w_len_nxt   = L;
                    w_sr_nxt    = D << w_load_shamt;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_SEND;
                end
            end

            ST_SEND: begin
                w_x     = r_sr[15];
                w_valid = 1'b1;
                w_busy  = 1'b1;
                if (step) begin
                    if (r_cnt == r_len) begin
                        w_done_nxt = 1'b1;
                        w_cnt_nxt  = 4'd0;
                        if (M) begin
                            w_sr_nxt = r_pat << w_reload_shamt;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_sr_nxt  = {r_sr[14:0], 1'b0};
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign X     = w_x;
    assign valid = w_valid;
    assign busy  = w_busy;
    assign done  = r_done;
    assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_pattern_tx
//  Purpose  : Self-checking bench for serial_pattern_tx. Directed frames with
//             known bit sequences, then randomized stimulus compared against a
//             behavioural model that tracks the captured word and bit index.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_pattern_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        start;
    logic        M;
    logic [15:0] D;
    logic [3:0]  L;
    logic        X;
    logic        valid;
    logic        busy;
    logic        done;
    logic [3:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the frame is the captured word read at bit
    // (len - idx); no shift register is modelled.
    logic        m_busy = 1'b0;
    logic [15:0] m_pat  = 16'd0;
    int          m_len  = 0;
    int          m_idx  = 0;
    logic        m_done = 1'b0;

    serial_pattern_tx u_dut (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .start (start),
        .M     (M),
        .D     (D),
        .L     (L),
        .X     (X),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_done = 1'b0;
            m_pat  = 16'd0;
            m_len  = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_pat  = D;
                m_len  = int'(L);
                m_idx  = 0;
            end
        end else begin
            m_done = 1'b0;
            if (step) begin
                if (m_idx == m_len) begin
                    m_done = 1'b1;
                    m_idx  = 0;
                    if (!M) m_busy = 1'b0;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic exp_x;
        exp_x = m_busy ? m_pat[m_len - m_idx] : 1'b0;
        chk({tag, ".X"},     32'(X),     32'(exp_x));
        chk({tag, ".valid"}, 32'(valid), 32'(m_busy));
        chk({tag, ".busy"},  32'(busy),  32'(m_busy));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".cnt"},   32'(cnt),   32'(m_idx));
    endtask

    // Apply the currently driven inputs across one rising edge, then check.
    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        step  = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick("rst");
        reset = 1'b0;
    endtask

    task automatic begin_frame(input logic [15:0] d, input logic [3:0] l, input logic m);
        D = d; L = l; M = m; start = 1'b1;
        tick("start");
        start = 1'b0;
    endtask

    // Walk n steps checking X against seq (bit n-1 first) and cnt against
    // the position within a frame of length flen.
    task automatic walk(input string tag, input logic [15:0] seq, input int n, input int flen);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".xseq"}, 32'(X), 32'(seq[n - 1 - i]));
            chk({tag, ".cntseq"}, 32'(cnt), 32'(i % flen));
            step = 1'b1;
            tick(tag);
            step = 1'b0;
            chk({tag, ".donepulse"}, 32'(done), 32'(((i + 1) % flen) == 0));
            tick(tag);
            chk({tag, ".donelow"}, 32'(done), 32'd0);
        end
    endtask

    logic [15:0] seq;

    initial begin
        reset = 1'b1; step = 1'b0; start = 1'b0; M = 1'b0; D = 16'd0; L = 4'd0;
        tick("rst0");
        tick("rst1");
        reset = 1'b0;

        // One-shot 6-bit frame
        begin_frame(16'h0016, 4'd5, 1'b0);
        seq = 16'b0000_0000_0001_0110;
        walk("oneshot", seq, 6, 6);
        chk("oneshot.idle_busy", 32'(busy), 32'd0);
        chk("oneshot.idle_x", 32'(X), 32'd0);

        // Repeat mode: sequence twice, busy holds
        begin_frame(16'h0016, 4'd5, 1'b1);
        seq = 16'b0000_0101_1001_0110;
        walk("repeat", seq, 12, 6);
        chk("repeat.busy", 32'(busy), 32'd1);
        M = 1'b0;
        walk("repeat_end", 16'h0016, 6, 6);
        chk("repeat_end.busy", 32'(busy), 32'd0);

        // Full width, D/L changes mid-frame ignored
        begin_frame(16'hA5C3, 4'd15, 1'b0);
        D = 16'h1234; L = 4'd2;
        walk("full", 16'hA5C3, 16, 16);
        chk("full.busy", 32'(busy), 32'd0);

        // Reset mid-frame
        begin_frame(16'h0016, 4'd5, 1'b0);
        walk("pre_rst", 16'h0016 >> 3, 3, 6);
        reset = 1'b1; step = 1'b1; start = 1'b1;
        tick("midrst");
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.cnt", 32'(cnt), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick("post_rst"); step = 1'b0; tick("post_rst");
        end

        // start reasserted during SEND with a different D
        begin_frame(16'h0016, 4'd5, 1'b0);
        D = 16'hFFFF; L = 4'd15; start = 1'b1;
        tick("restart");
        start = 1'b0;
        walk("restart", 16'h0016, 6, 6);

        // start and step in the same IDLE cycle
        D = 16'h0020; L = 4'd5; M = 1'b0; start = 1'b1; step = 1'b1;
        tick("startstep");
        idle_inputs();
        chk("startstep.cnt", 32'(cnt), 32'd0);
        chk("startstep.x", 32'(X), 32'd1);
        walk("startstep", 16'h0020, 6, 6);

        // One-bit frame
        begin_frame(16'h0001, 4'd0, 1'b0);
        chk("onebit.x", 32'(X), 32'd1);
        walk("onebit", 16'h0001, 1, 1);
        chk("onebit.busy", 32'(busy), 32'd0);

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 7) == 0);
            step  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) M = 1'($urandom);
            D = 16'($urandom);
            L = 4'($urandom);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
